// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// CHK exists only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int ISA_WIDTH = 16;
    localparam logic [15:0] ADDR_STRIDE = 16'd2;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DAT_HI = 3'd2,
        DAT_LO = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHK    = 3'd4,
`endif
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream boot loader: length-prefixed words into instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 imem_we,
    output logic [15:0]          imem_addr,
    output logic [ISA_WIDTH-1:0] imem_wdata,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 error
);

    localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t      state;
    logic [7:0]  hi_byte;
    logic [15:0] word_total;
    logic [15:0] word_cnt;
    logic [15:0] len;
    logic        xfer;

    assign xfer = byte_valid & byte_ready;
    assign len  = {hi_byte, byte_data};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'h00;
        end else if (xfer && state != CHK) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LEN_HI;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            hi_byte    <= 8'h00;
            word_total <= '0;
            word_cnt   <= '0;
        end else begin
            imem_we    <= 1'b0;
            byte_ready <= 1'b1;
            // Delayed by one cycle so the last write lands first.
            cpu_reset  <= ~done;
            case (state)
                LEN_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_data;
                        state   <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        word_total <= len;
                        if (len == 16'd0) begin
                            state      <= END_ST;
                            done       <= (END_ST == DONE);
                            byte_ready <= (END_ST != DONE);
                        end else if ({1'b0, len} > MAX_WORDS) begin
                            state      <= ERR;
                            error      <= 1'b1;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= DAT_HI;
                        end
                    end
                end
                DAT_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_data;
                        state   <= DAT_LO;
                    end
                end
                DAT_LO: begin
                    if (xfer) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= len;
                        imem_addr  <= word_cnt * ADDR_STRIDE;
                        word_cnt   <= word_cnt + 16'd1;
                        if (word_cnt + 16'd1 == word_total) begin
                            state      <= END_ST;
                            done       <= (END_ST == DONE);
                            byte_ready <= (END_ST != DONE);
                        end else begin
                            state <= DAT_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: byte_ready <= 1'b0;
            endcase
        end
    end

endmodule
